// File: rtl/psr_branch_eval.sv
// Branch resolver that waits for in-flight flag writers before evaluating a condition on the PSR.
// Optional macro PSR_FWD_EN lets the last outstanding writeback be forwarded into evaluation.
module psr_branch_eval #(
    parameter int unsigned PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_issue,
    output logic       issue_ready,
    input  logic       flag_wr_valid,
    input  logic [4:0] flag_wr_data,
    input  logic       br_valid,
    input  logic [3:0] br_cond,
    output logic       br_ready,
    output logic       br_done,
    output logic       br_taken,
    output logic [4:0] psr_q,
    output logic       err
);

    typedef enum logic {StIdle, StEval} state_t;

    localparam logic [PEND_W-1:0] PendMax = '1;

    state_t            state_q, state_d;
    logic [3:0]        cond_q, cond_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [4:0]        eval_flags;
    logic              resolve;
    logic              issue_acc;
    logic              cond_err;

    // Flag bits: {carry, nonzero, zero, even, parity}.
    function automatic logic cond_taken(input logic [3:0] c, input logic [4:0] f);
        logic t;
        case (c)
            4'd0:    t = 1'b1;
            4'd1:    t = 1'b0;
            4'd2:    t = f[2];
            4'd3:    t = f[3];
            4'd4:    t = f[4];
            4'd5:    t = ~f[4];
            4'd6:    t = f[1];
            4'd7:    t = ~f[1];
            4'd8:    t = f[0];
            4'd9:    t = ~f[0];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign issue_ready = (pend_q != PendMax);
    assign br_ready    = (state_q == StIdle);
    assign issue_acc   = flag_issue && issue_ready;

    always_comb begin
        pend_d = pend_q;
        if (issue_acc && !flag_wr_valid) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (flag_wr_valid && !issue_acc && pend_q != '0) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cond_d     = cond_q;
        br_done    = 1'b0;
        br_taken   = 1'b0;
        cond_err   = 1'b0;
        eval_flags = psr_q;
        resolve    = (pend_q == '0);
`ifdef PSR_FWD_EN
        // The one remaining writer is delivering now; use its flags directly.
        if (pend_q == PEND_W'(1) && flag_wr_valid) begin
            resolve    = 1'b1;
            eval_flags = flag_wr_data;
        end
`endif
        unique case (state_q)
            StIdle: begin
                if (br_valid) begin
                    cond_d  = br_cond;
                    state_d = StEval;
                end
            end
            StEval: begin
                // Reset abandons the branch, so no pulse while rst is high.
                if (resolve && !rst) begin
                    br_done  = 1'b1;
                    br_taken = cond_taken(cond_q, eval_flags);
                    cond_err = (cond_q > 4'd9);
                    state_d  = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cond_q  <= '0;
            pend_q  <= '0;
            psr_q   <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            pend_q  <= pend_d;
            if (flag_wr_valid) begin
                psr_q <= flag_wr_data;
            end
            if ((flag_issue && !issue_ready) || (flag_wr_valid && pend_q == '0) || cond_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psr_branch_eval.sv
// Directed self-checking bench for psr_branch_eval; adapts forwarding expectations to PSR_FWD_EN.
module tb_psr_branch_eval;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_issue;
    logic       issue_ready;
    logic       flag_wr_valid;
    logic [4:0] flag_wr_data;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_ready;
    logic       br_done;
    logic       br_taken;
    logic [4:0] psr_q;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psr_branch_eval #(.PEND_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flag_issue   (flag_issue),
        .issue_ready  (issue_ready),
        .flag_wr_valid(flag_wr_valid),
        .flag_wr_data (flag_wr_data),
        .br_valid     (br_valid),
        .br_cond      (br_cond),
        .br_ready     (br_ready),
        .br_done      (br_done),
        .br_taken     (br_taken),
        .psr_q        (psr_q),
        .err          (err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Branch accepted this cycle, resolved with no pending writers in the next.
    task automatic branch(input logic [3:0] c, input logic exp_taken, input string tag);
        br_valid = 1'b1;
        br_cond  = c;
        settle();
        check({tag, " ready"}, 8'(br_ready), 8'd1);
        cyc();
        br_valid = 1'b0;
        settle();
        check({tag, " done"}, 8'(br_done), 8'd1);
        check({tag, " taken"}, 8'(br_taken), 8'(exp_taken));
        cyc();
    endtask

    task automatic expect_reset_state(input string tag);
        check({tag, " psr"}, 8'(psr_q), 8'h00);
        check({tag, " err"}, 8'(err), 8'd0);
        check({tag, " br_ready"}, 8'(br_ready), 8'd1);
        check({tag, " issue_ready"}, 8'(issue_ready), 8'd1);
        check({tag, " br_done"}, 8'(br_done), 8'd0);
        check({tag, " br_taken"}, 8'(br_taken), 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        flag_issue = 1'b0;
        flag_wr_valid = 1'b0;
        flag_wr_data = '0;
        br_valid = 1'b0;
        br_cond = '0;
        repeat (2) cyc();
        rst = 1'b0;
        settle();
        expect_reset_state("reset");

        // Always-taken branch: done at N+1, ready again at N+2.
        branch(4'd0, 1'b1, "always");
        settle();
        check("always ready_n2", 8'(br_ready), 8'd1);
        check("always done_n2", 8'(br_done), 8'd0);
        check("always taken_n2", 8'(br_taken), 8'd0);

        // Load PSR = 00100 through a legitimate writer.
        flag_issue = 1'b1;
        cyc();
        flag_issue = 1'b0;
        flag_wr_valid = 1'b1;
        flag_wr_data = 5'b00100;
        cyc();
        flag_wr_valid = 1'b0;
        settle();
        check("psr load", 8'(psr_q), 8'h04);
        check("psr load err", 8'(err), 8'd0);
        branch(4'd2, 1'b1, "Z");
        branch(4'd3, 1'b0, "NZ");
        branch(4'd7, 1'b1, "ODD");
        branch(4'd1, 1'b0, "never");
        branch(4'd4, 1'b0, "C");
        branch(4'd5, 1'b1, "NC");
        branch(4'd6, 1'b0, "EVEN");
        branch(4'd8, 1'b0, "PAR");
        branch(4'd9, 1'b1, "NPAR");
        settle();
        check("conds err", 8'(err), 8'd0);

        // Branch waits for an outstanding writer issued one cycle earlier.
        flag_issue = 1'b1;
        cyc();
        flag_issue = 1'b0;
        br_valid = 1'b1;
        br_cond = 4'd4;
        cyc();
        br_valid = 1'b0;
        settle();
        check("wait c2 done", 8'(br_done), 8'd0);
        check("wait c2 ready", 8'(br_ready), 8'd0);
        cyc();
        check("wait c3 done", 8'(br_done), 8'd0);
        cyc();
        flag_wr_valid = 1'b1;
        flag_wr_data = 5'b10000;
        settle();
`ifdef PSR_FWD_EN
        check("fwd c4 done", 8'(br_done), 8'd1);
        check("fwd c4 taken", 8'(br_taken), 8'd1);
`else
        check("nofwd c4 done", 8'(br_done), 8'd0);
`endif
        cyc();
        flag_wr_valid = 1'b0;
        settle();
        check("c5 psr", 8'(psr_q), 8'h10);
`ifdef PSR_FWD_EN
        check("fwd c5 done", 8'(br_done), 8'd0);
        check("fwd c5 ready", 8'(br_ready), 8'd1);
`else
        check("nofwd c5 done", 8'(br_done), 8'd1);
        check("nofwd c5 taken", 8'(br_taken), 8'd1);
`endif
        cyc();

        // Issue in the same cycle as branch accept is ordered before the branch.
        flag_issue = 1'b1;
        br_valid = 1'b1;
        br_cond = 4'd5;
        cyc();
        flag_issue = 1'b0;
        br_valid = 1'b0;
        settle();
        check("order n1 done", 8'(br_done), 8'd0);
        cyc();
        flag_wr_valid = 1'b1;
        flag_wr_data = 5'b00000;
        settle();
`ifdef PSR_FWD_EN
        check("order fwd done", 8'(br_done), 8'd1);
        check("order fwd taken", 8'(br_taken), 8'd1);
        cyc();
        flag_wr_valid = 1'b0;
`else
        check("order nofwd n2 done", 8'(br_done), 8'd0);
        cyc();
        flag_wr_valid = 1'b0;
        settle();
        check("order nofwd done", 8'(br_done), 8'd1);
        check("order nofwd taken", 8'(br_taken), 8'd1);
        cyc();
`endif
        settle();
        check("order err", 8'(err), 8'd0);

        // Counter saturation and overflow error.
        flag_issue = 1'b1;
        repeat (3) cyc();
        settle();
        check("full issue_ready", 8'(issue_ready), 8'd0);
        check("full err before", 8'(err), 8'd0);
        cyc();
        flag_issue = 1'b0;
        settle();
        check("overflow err", 8'(err), 8'd1);
        check("overflow still full", 8'(issue_ready), 8'd0);
        flag_wr_valid = 1'b1;
        flag_wr_data = 5'b00000;
        cyc();
        settle();
        check("cnt2 issue_ready", 8'(issue_ready), 8'd1);
        flag_issue = 1'b1;
        cyc();
        flag_wr_valid = 1'b0;
        settle();
        check("both keeps cnt", 8'(issue_ready), 8'd1);
        cyc();
        flag_issue = 1'b0;
        settle();
        check("cnt back to 3", 8'(issue_ready), 8'd0);
        flag_wr_valid = 1'b1;
        repeat (3) cyc();
        flag_wr_valid = 1'b0;
        settle();
        check("drained issue_ready", 8'(issue_ready), 8'd1);
        branch(4'd0, 1'b1, "drained");

        // Reserved condition code.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check("rst2 err", 8'(err), 8'd0);
        branch(4'd12, 1'b0, "cond12");
        settle();
        check("cond12 err", 8'(err), 8'd1);

        // Reset while a branch waits on two writers.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        flag_issue = 1'b1;
        repeat (4) cyc();
        flag_issue = 1'b0;
        flag_wr_valid = 1'b1;
        flag_wr_data = 5'b11111;
        cyc();
        flag_wr_valid = 1'b0;
        br_valid = 1'b1;
        br_cond = 4'd0;
        cyc();
        br_valid = 1'b0;
        settle();
        check("eval psr", 8'(psr_q), 8'h1f);
        check("eval err", 8'(err), 8'd1);
        check("eval waiting", 8'(br_done), 8'd0);
        rst = 1'b1;
        settle();
        check("rst mid eval done", 8'(br_done), 8'd0);
        cyc();
        rst = 1'b0;
        settle();
        expect_reset_state("rst mid eval");
        branch(4'd0, 1'b1, "post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psr_branch_eval.md
PSR_BRANCH_EVAL -- requirements
Module: psr_branch_eval

Interface
REQ-001 SHALL have parameter PEND_W, default 2: width of the in-flight flag-writer counter (max outstanding = 2^PEND_W - 1).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flag_issue  in  1  a flag-writing instruction issued this cycle
- issue_ready  out  1  high when a flag_issue can be accepted
- flag_wr_valid  in  1  writeback delivers new program status this cycle
- flag_wr_data  in  5  program status {carry, nonzero, zero, even, parity}, bit4..bit0
- br_valid  in  1  branch request from decode
- br_cond  in  4  condition code
- br_ready  out  1  branch request accepted when br_valid && br_ready
- br_done  out  1  one-cycle pulse when the branch is resolved
- br_taken  out  1  resolution result; meaningful only while br_done is high
- psr_q  out  5  architectural status register
- err  out  1  sticky error flag
REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 psr_q SHALL load flag_wr_data on every cycle in which flag_wr_valid is high.
REQ-005 pend_cnt (PEND_W bits) SHALL update as follows:
- +1 on accepted flag_issue only
- -1 on flag_wr_valid only
- unchanged when both occur in the same cycle
REQ-006 issue_ready SHALL be low when pend_cnt equals its maximum; flag_issue while issue_ready is low SHALL be ignored and SHALL set err.
REQ-007 flag_wr_valid with pend_cnt==0 SHALL still write psr_q, SHALL leave pend_cnt at 0, and SHALL set err.
REQ-008 The FSM SHALL have states IDLE and EVAL. br_ready SHALL be high only in IDLE.
REQ-009 In IDLE, an accepted branch SHALL capture br_cond and move to EVAL.
REQ-010 In EVAL:
- if pend_cnt==0, SHALL evaluate using psr_q, pulse br_done, and return to IDLE
- otherwise SHALL remain in EVAL
REQ-011 Minimum latency SHALL be accept at cycle N and br_done at cycle N+1.
REQ-012 Condition codes (flag bit numbers refer to psr_q):
- 0 always
- 1 never
- 2 Z (bit2)
- 3 NZ (bit3)
- 4 C (bit4)
- 5 NC (!bit4)
- 6 EVEN (bit1)
- 7 ODD (!bit1)
- 8 PAR (bit0)
- 9 NPAR (!bit0)
REQ-013 Codes 10-15 SHALL resolve not-taken with br_done asserted and SHALL set err.
REQ-014 A flag_issue in the same cycle a branch is accepted SHALL be ordered before that branch, so the branch waits for it.
REQ-015 br_taken SHALL be 0 whenever br_done is 0.

Reset
REQ-016 While rst is high on a clock edge, the block SHALL set:
- psr_q=0, pend_cnt=0, state=IDLE
- br_done=0, br_taken=0, err=0
- captured condition cleared
REQ-017 Reset mid-EVAL SHALL abandon the pending branch with no br_done pulse.
REQ-018 br_ready and issue_ready SHALL read 1 in the first cycle after reset.

Configuration
REQ-019 Macro PSR_FWD_EN SHALL control forwarding:
- defined: in EVAL with pend_cnt==1 and flag_wr_valid high, the branch SHALL be evaluated on flag_wr_data and br_done SHALL pulse that same cycle
- undefined: the branch SHALL wait until pend_cnt==0 and evaluate psr_q, one cycle later
REQ-020 Outputs other than br_done/br_taken timing SHALL be identical with and without PSR_FWD_EN.

Verification
REQ-021 After reset, psr_q=00000 and br_cond=0 accepted at cycle N -> br_done=1 and br_taken=1 at N+1; br_ready=1 at N+2.
REQ-022 flag_wr_valid with data 00100, then br_cond=2 -> taken; br_cond=3 -> not taken; br_cond=7 -> taken.
REQ-023 flag_issue at cycle 0, branch br_cond=4 accepted at cycle 1, flag_wr_valid with data 10000 at cycle 4:
- with PSR_FWD_EN: br_done=1, br_taken=1 at cycle 4
- without PSR_FWD_EN: same result at cycle 5
REQ-024 With PEND_W=2, issue 3 flag writers -> issue_ready=0; a 4th flag_issue -> err=1 and pend_cnt stays 3; simultaneous issue+wr -> pend_cnt unchanged.
REQ-025 br_cond=12 -> br_done=1, br_taken=0, err=1.
REQ-026 rst asserted while in EVAL with pend_cnt=2 -> no br_done, and all REQ-016 values hold the next cycle.
